id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 32 +++
 rtl/id_ex_stage_load_use_detect.sv | 47 ++++
 rtl/id_ex_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared opcode and control-bit definitions for the decode/execute pipeline.
// Contents:
//   - field widths for control, data and register specifiers
//   - MIPS-style opcode constants
//   - bit positions inside the 7-bit decoded control word
package id_ex_stage_pkg;

   localparam int CTRL_W = 7;
   localparam int OPC_W  = 6;
   localparam int DATA_W = 96;
   localparam int REG_W  = 5;

   // Opcode constants
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_MULTYPE = 6'h1C;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // Control word bit positions, MSB first: {regWrite, memToReg, branch,
   // memRead, memWrite, ALUsrc, regDst}
   localparam int CTRL_REG_WRITE = 6;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_BRANCH    = 4;
   localparam int CTRL_MEM_READ  = 3;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_ALU_SRC   = 1;
   localparam int CTRL_REG_DST   = 0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_valid, ex_mem_read, ex_rt : instruction currently in EX
//   id_rs, id_rt, id_opcode      : instruction currently in decode
//   flush                        : squash in progress, suppresses the stall
//   hazard_stall                 : 1 = freeze PC and IF/ID, bubble into EX
module load_use_detect
   import id_ex_stage_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [OPC_W-1:0] id_opcode,
   input  logic             flush,
   output logic             hazard_stall
);

   logic reads_rt_s;
   logic rs_match_s;
   logic rt_match_s;

   // Classify which decode opcodes actually read rt as a source operand
   always_comb begin
      reads_rt_s = 1'b0;
      case (id_opcode)
         OP_RTYPE, OP_MULTYPE, OP_BEQ, OP_BNE, OP_SW: reads_rt_s = 1'b1;
         default:                                     reads_rt_s = 1'b0;
      endcase
   end

   // A load writing $zero never creates a dependency, and a flush kills the stall
   always_comb begin
      rs_match_s   = (ex_rt == id_rs);
      rt_match_s   = (ex_rt == id_rt) && reads_rt_s;
      hazard_stall = 1'b0;
      if (flush) begin
         hazard_stall = 1'b0;
      end else if (ex_valid && ex_mem_read && (ex_rt != 5'd0)) begin
         hazard_stall = rs_match_s || rt_match_s;
      end else begin
         hazard_stall = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_ctrl/opcode/data/rs/rt/rd    : decoded instruction fields
//   flush, hold                     : squash and freeze requests from downstream
//   ex_ctrl/opcode/data/rs/rt/rd    : registered instruction fields for EX
//   ex_valid                        : 1 = real instruction, 0 = bubble
//   hazard_stall                    : combinational load-use stall to IF/ID
//   bubble_count                    : saturating count of inserted stall bubbles
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [OPC_W-1:0]  id_opcode,
   input  logic [DATA_W-1:0] id_data,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   input  logic              hold,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [OPC_W-1:0]  ex_opcode,
   output logic [DATA_W-1:0] ex_data,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_valid,
   output logic              hazard_stall,
   output logic [CNT_W-1:0]  bubble_count
);

   logic [CTRL_W-1:0] ex_ctrl_r;
   logic [OPC_W-1:0]  ex_opcode_r;
   logic [DATA_W-1:0] ex_data_r;
   logic [REG_W-1:0]  ex_rs_r;
   logic [REG_W-1:0]  ex_rt_r;
   logic [REG_W-1:0]  ex_rd_r;
   logic              ex_valid_r;
   logic [CNT_W-1:0]  bubble_count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic              hazard_s;

   load_use_detect u_detect (
      .ex_valid     (ex_valid_r),
      .ex_mem_read  (ex_ctrl_r[CTRL_MEM_READ]),
      .ex_rt        (ex_rt_r),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_opcode    (id_opcode),
      .flush        (flush),
      .hazard_stall (hazard_s)
   );

   // Saturating increment: the counter sticks at all-ones instead of wrapping
   always_comb begin
      count_next_s = bubble_count_r;
      if (bubble_count_r == {CNT_W{1'b1}}) begin
         count_next_s = bubble_count_r;
      end else begin
         count_next_s = bubble_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Pipeline register: flush beats hold beats stall beats load; data fields
   // are kept on flush and bubble so only the control word is cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl_r      <= 7'd0;
         ex_opcode_r    <= 6'd0;
         ex_data_r      <= 96'd0;
         ex_rs_r        <= 5'd0;
         ex_rt_r        <= 5'd0;
         ex_rd_r        <= 5'd0;
         ex_valid_r     <= 1'b0;
         bubble_count_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         ex_ctrl_r  <= 7'd0;
         ex_valid_r <= 1'b0;
      end else if (!hold) begin
         if (hazard_s) begin
            ex_ctrl_r      <= 7'd0;
            ex_valid_r     <= 1'b0;
            bubble_count_r <= count_next_s;
         end else begin
            ex_ctrl_r   <= id_ctrl;
            ex_opcode_r <= id_opcode;
            ex_data_r   <= id_data;
            ex_rs_r     <= id_rs;
            ex_rt_r     <= id_rt;
            ex_rd_r     <= id_rd;
            ex_valid_r  <= 1'b1;
         end
      end
   end

   assign ex_ctrl      = ex_ctrl_r;
   assign ex_opcode    = ex_opcode_r;
   assign ex_data      = ex_data_r;
   assign ex_rs        = ex_rs_r;
   assign ex_rt        = ex_rt_r;
   assign ex_rd        = ex_rd_r;
   assign ex_valid     = ex_valid_r;
   assign hazard_stall = hazard_s;
   assign bubble_count = bubble_count_r;

endmodule
